// File: rtl/ex_muldiv_sequencer.sv
// EX-stage multiply/divide unit: owns HI/LO, runs one 32-iteration radix-2 multiply or restoring divide.
// Optional build macro: MULDIV_FAST_MUL_EN selects a single-cycle MULT/MULTU path.
module ex_muldiv_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int MSB = DATA_W - 1;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] acc;        // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [DATA_W-1:0]   opb_mag;
    logic                is_div, neg_res, neg_rem, div_zero;

    logic                take, is_mul_op, is_div_op, iter_op, accept_iter, signed_op, last_iter;
    logic [DATA_W-1:0]   opa_mag_in, opb_mag_in;
    logic [DATA_W:0]     mul_sum, div_diff;
    logic [2*DATA_W-1:0] acc_step, prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    assign take      = start & ~flush & (state == IDLE);
    assign is_mul_op = (op == OP_MULT) | (op == OP_MULTU);
    assign is_div_op = (op == OP_DIV)  | (op == OP_DIVU);
    assign signed_op = (op == OP_MULT) | (op == OP_DIV);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*DATA_W-1:0] fast_prod;
    assign fast_prod = signed_op ? ({{DATA_W{opa[MSB]}}, opa} * {{DATA_W{opb[MSB]}}, opb})
                                 : ({{DATA_W{1'b0}}, opa} * {{DATA_W{1'b0}}, opb});
    assign iter_op = is_div_op;
`else
    assign iter_op = is_mul_op | is_div_op;
`endif

    assign accept_iter = take & iter_op;
    assign busy        = (state == RUN);
    assign stall       = busy | accept_iter;
    assign last_iter   = &count;

    assign opa_mag_in = (signed_op && opa[MSB]) ? -opa : opa;
    assign opb_mag_in = (signed_op && opb[MSB]) ? -opb : opb;

    // One iteration: shift-add for multiply, trial-subtract-and-restore for divide.
    assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opb_mag} : '0);
    assign div_diff = acc[2*DATA_W-1:DATA_W-1] - {1'b0, opb_mag};
    assign acc_step = is_div ? (div_diff[DATA_W] ? {acc[2*DATA_W-2:0], 1'b0}
                                                 : {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1})
                             : {mul_sum, acc[DATA_W-1:1]};

    assign prod_fix = neg_res ? -acc_step : acc_step;
    assign quo_fix  = div_zero ? '1 : (neg_res ? -acc_step[DATA_W-1:0] : acc_step[DATA_W-1:0]);
    assign rem_fix  = neg_rem ? -acc_step[2*DATA_W-1:DATA_W] : acc_step[2*DATA_W-1:DATA_W];

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_iter) state_next = RUN;
            RUN:     if (flush || last_iter) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            acc      <= '0;
            opb_mag  <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                count <= '0;
                if (accept_iter) begin
                    acc      <= {{DATA_W{1'b0}}, opa_mag_in};
                    opb_mag  <= opb_mag_in;
                    is_div   <= is_div_op;
                    neg_res  <= signed_op & (opa[MSB] ^ opb[MSB]);
                    neg_rem  <= signed_op & opa[MSB];
                    div_zero <= is_div_op & (opb == '0);
                end
`ifdef MULDIV_FAST_MUL_EN
                else if (take && is_mul_op) begin
                    {hi, lo} <= fast_prod;
                    done     <= 1'b1;
                end
`endif
                else if (take && op == OP_MTHI) begin
                    hi <= opa;
                end else if (take && op == OP_MTLO) begin
                    lo <= opa;
                end
            end else if (!flush) begin
                acc   <= acc_step;
                count <= count + 1'b1;
                if (last_iter) begin
                    done <= 1'b1;
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: directed corner cases plus randomized ops
// checked against an arithmetic reference model (honours MULDIV_FAST_MUL_EN).
module tb_ex_muldiv_sequencer;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1, flush = 1'b0, start = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  opa = '0, opb = '0;
    logic          stall, busy, done;
    logic [W-1:0]  hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a, b, h, l;
    } vec_t;

    localparam vec_t DVEC [8] = '{
        '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
        '{3'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB},
        '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
        '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
        '{3'd4, 32'd100,      32'd7,        32'd2,        32'd14},
        '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
        '{3'd4, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF},
        '{3'd3, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF}
    };

    ex_muldiv_sequencer dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
        .opa(opa), .opb(opb), .stall(stall), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          q, r;
        longint unsigned uq, ur;
        case (o)
            3'd1: return sa * sb;
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o);
        return (FAST && (o == 3'd1 || o == 3'd2)) ? 1 : 33;
    endfunction

    function automatic int exp_stall(input logic [2:0] o);
        return (FAST && (o == 3'd1 || o == 3'd2)) ? 0 : 33;
    endfunction

    // Bounded wait for done; lat = -1 when the budget expires.
    task automatic wait_done(input int c0, output int lat, output int stl, output logic [W-1:0] rh, output logic [W-1:0] rl);
        lat = -1; stl = 0; rh = 'x; rl = 'x;
        for (int c = c0; c <= 40; c++) begin
            if (done) begin
                lat = c; rh = hi; rl = lo;
                break;
            end
            if (stall) stl++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int stl, output logic [W-1:0] rh, output logic [W-1:0] rl);
        int s0;
        start = 1'b1; op = o; opa = a; opb = b;
        #1;
        s0 = stall ? 1 : 0;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        #1;
        wait_done(1, lat, stl, rh, rl);
        stl += s0;
    endtask

    task automatic do_mt(input logic [2:0] o, input logic [W-1:0] v);
        start = 1'b1; op = o; opa = v;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, stall} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ctrl: got busy/done/stall=%b, expected 000", {busy, done, stall});
        end
        n_cmp++;
        if ({hi, lo} !== 64'd0) begin
            n_bad++; $display("FAIL reset_hilo: got hi=%h lo=%h, expected 0/0", hi, lo);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int lat, stl;
        logic [W-1:0] rh, rl;
        for (int i = 0; i < 8; i++) begin
            run_op(DVEC[i].op, DVEC[i].a, DVEC[i].b, lat, stl, rh, rl);
            n_cmp++;
            if ({rh, rl} !== {DVEC[i].h, DVEC[i].l}) begin
                n_bad++; $display("FAIL directed[%0d]_result: got hi=%h lo=%h, expected hi=%h lo=%h", i, rh, rl, DVEC[i].h, DVEC[i].l);
            end
            n_cmp++;
            if (lat !== exp_lat(DVEC[i].op)) begin
                n_bad++; $display("FAIL directed[%0d]_latency: got %0d, expected %0d", i, lat, exp_lat(DVEC[i].op));
            end
            n_cmp++;
            if (stl !== exp_stall(DVEC[i].op)) begin
                n_bad++; $display("FAIL directed[%0d]_stall_cycles: got %0d, expected %0d", i, stl, exp_stall(DVEC[i].op));
            end
            @(negedge clk);
            n_cmp++;
            if ({done, busy, stall} !== 3'b000) begin
                n_bad++; $display("FAIL directed[%0d]_after_done: got done/busy/stall=%b, expected 000", i, {done, busy, stall});
            end
        end
    endtask

    task automatic test_random_back_to_back();
        int lat, stl;
        logic [2:0]   o;
        logic [W-1:0] a, b, rh, rl;
        logic [63:0]  e;
        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(1, 4));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            e = model(o, a, b);
            run_op(o, a, b, lat, stl, rh, rl);
            n_cmp++;
            if ({rh, rl} !== e) begin
                n_bad++; $display("FAIL random[%0d]_result op=%0d a=%h b=%h: got hi=%h lo=%h, expected hi=%h lo=%h",
                                  i, o, a, b, rh, rl, e[63:32], e[31:0]);
            end
            n_cmp++;
            if (lat !== exp_lat(o) || stl !== exp_stall(o)) begin
                n_bad++; $display("FAIL random[%0d]_timing op=%0d: got lat=%0d stall=%0d, expected lat=%0d stall=%0d",
                                  i, o, lat, stl, exp_lat(o), exp_stall(o));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1; op = 3'd5; opa = 32'h0000ABCD;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL mthi_stall: got %b, expected 0", stall);
        end
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        #1;
        n_cmp++;
        if ({hi, done, busy} !== {32'h0000ABCD, 2'b00}) begin
            n_bad++; $display("FAIL mthi_write: got hi=%h done=%b busy=%b, expected hi=0000abcd done=0 busy=0", hi, done, busy);
        end
        do_mt(3'd6, 32'h12345678);
        n_cmp++;
        if ({hi, lo} !== {32'h0000ABCD, 32'h12345678}) begin
            n_bad++; $display("FAIL mtlo_write: got hi=%h lo=%h, expected hi=0000abcd lo=12345678", hi, lo);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        do_mt(3'd5, 32'h11);
        do_mt(3'd6, 32'h11);
        start = 1'b1; op = 3'd4; opa = 32'd100; opb = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL flush_busy_before: got %b, expected 1", busy);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_cmp++;
        if ({busy, stall, hi, lo} !== {2'b00, 32'h11, 32'h11}) begin
            n_bad++; $display("FAIL flush_after: got busy=%b stall=%b hi=%h lo=%h, expected 0 0 11 11", busy, stall, hi, lo);
        end
        for (int c = 0; c < 40; c++) begin
            if (done) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++; $display("FAIL flush_done_pulses: got %0d, expected 0", seen);
        end
    endtask

    task automatic test_start_flush();
        start = 1'b1; flush = 1'b1; op = 3'd4; opa = 32'd9; opb = 32'd3;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL start_flush_stall: got %b, expected 0", stall);
        end
        @(negedge clk);
        op = 3'd5; opa = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; op = 3'd0;
        #1;
        n_cmp++;
        if ({busy, stall, hi, lo} !== {2'b00, 32'h11, 32'h11}) begin
            n_bad++; $display("FAIL start_flush_after: got busy=%b stall=%b hi=%h lo=%h, expected 0 0 11 11", busy, stall, hi, lo);
        end
    endtask

    task automatic test_start_during_run();
        int lat, stl;
        logic [W-1:0] rh, rl;
        start = 1'b1; op = 3'd4; opa = 32'd100; opb = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd2; opa = 32'd3; opb = 32'd5;
        @(negedge clk);
        start = 1'b1; op = 3'd5; opa = 32'hBAD;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        #1;
        wait_done(7, lat, stl, rh, rl);
        n_cmp++;
        if ({rh, rl} !== {32'd2, 32'd14} || lat !== 33) begin
            n_bad++; $display("FAIL start_in_run: got hi=%h lo=%h lat=%0d, expected hi=2 lo=e lat=33", rh, rl, lat);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, hi, lo} !== {2'b00, 32'd2, 32'd14}) begin
            n_bad++; $display("FAIL start_in_run_idle: got busy=%b done=%b hi=%h lo=%h, expected 0 0 2 e", busy, done, hi, lo);
        end
    endtask

    task automatic test_rst_mid_run();
        int lat, stl;
        logic [W-1:0] rh, rl;
        do_mt(3'd5, 32'h55);
        do_mt(3'd6, 32'h66);
        start = 1'b1; op = 3'd4; opa = 32'd100; opb = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({hi, lo, busy, done, stall} !== {64'd0, 3'b000}) begin
            n_bad++; $display("FAIL rst_mid_run: got hi=%h lo=%h busy=%b done=%b stall=%b, expected all 0", hi, lo, busy, done, stall);
        end
        run_op(3'd4, 32'd1000, 32'd33, lat, stl, rh, rl);
        n_cmp++;
        if ({rh, rl} !== {32'd10, 32'd30} || lat !== 33) begin
            n_bad++; $display("FAIL rst_then_op: got hi=%h lo=%h lat=%0d, expected hi=a lo=1e lat=33", rh, rl, lat);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_directed();
        test_random_back_to_back();
        test_flush();
        test_start_flush();
        test_start_during_run();
        test_rst_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
